// File: rtl/snax_tcdm_responder_pkg.sv
// Shared AMO encoding plus the responder's types, derived widths and address decode.
// The snax_tcdm_pkg localparams define the default configuration of the request/response structs.
package reqrsp_pkg;

  typedef enum logic [3:0] {
    AMONone = 4'h0,
    AMOSwap = 4'h1,
    AMOAdd  = 4'h2,
    AMOAnd  = 4'h3,
    AMOOr   = 4'h4,
    AMOXor  = 4'h5,
    AMOMax  = 4'h6,
    AMOMaxu = 4'h7,
    AMOMin  = 4'h8,
    AMOMinu = 4'h9,
    AMOLR   = 4'hA,
    AMOSC   = 4'hB
  } amo_op_e;

endpackage

package snax_tcdm_pkg;

  import reqrsp_pkg::*;

  localparam int unsigned DataWidth   = 64;
  localparam int unsigned AddrWidth   = 17;
  localparam int unsigned NumPorts    = 16;
  localparam int unsigned NumBanks    = 32;
  localparam int unsigned BankDepth   = 256;
  localparam int unsigned RspLatency  = 1;
  localparam int unsigned UserWidth   = 1;
  localparam int unsigned StrbWidth   = DataWidth / 8;
  localparam int unsigned ByteOffsetW = $clog2(StrbWidth);
  localparam int unsigned BankSelW    = $clog2(NumBanks);
  localparam int unsigned RowW        = $clog2(BankDepth);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    amo_op_e              amo;
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic [UserWidth-1:0] user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    tcdm_rsp_chan_t p;
    logic           p_valid;
    logic           q_ready;
  } tcdm_rsp_t;

  typedef struct packed {
    logic [BankSelW-1:0] bank;
    logic [RowW-1:0]     row;
  } tcdm_addr_dec_t;

  // Word-interleaved decode; truncation drops upper bits so the space aliases.
  function automatic tcdm_addr_dec_t decode_addr(input logic [AddrWidth-1:0] addr);
    tcdm_addr_dec_t         dec;
    logic [AddrWidth-1:0]   word;
    word     = addr >> ByteOffsetW;
    dec.bank = BankSelW'(word);
    dec.row  = RowW'(word >> BankSelW);
    return dec;
  endfunction

endpackage

// File: rtl/snax_tcdm_responder_if.sv
// Bundle of per-port TCDM request/response channels between requesters and the responder.
interface snax_tcdm_responder_if
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned NumPorts = snax_tcdm_pkg::NumPorts
);

  tcdm_req_t tcdm_req [NumPorts];
  tcdm_rsp_t tcdm_rsp [NumPorts];

  modport master (output tcdm_req, input tcdm_rsp);
  modport slave  (input tcdm_req, output tcdm_rsp);

endinterface

// File: rtl/snax_tcdm_responder_bank.sv
// One TCDM bank: round-robin arbiter over all ports, byte-strobed storage and a
// read-data register holding the word fetched at the grant edge.
module snax_tcdm_bank
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned NumPorts  = 16,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned BankDepth = 256,
  parameter int unsigned RowIdxW   = (BankDepth > 1) ? $clog2(BankDepth) : 1,
  parameter int unsigned StrbW     = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumPorts-1:0]  req_valid_i,
  input  logic [RowIdxW-1:0]   req_row_i   [NumPorts],
  input  logic [NumPorts-1:0]  req_write_i,
  input  logic [DataWidth-1:0] req_wdata_i [NumPorts],
  input  logic [StrbW-1:0]     req_strb_i  [NumPorts],
  output logic [NumPorts-1:0]  gnt_o,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned PortW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PortW-1:0]     ptr_d, ptr_q, sel, idx;
  logic                 found, gnt_valid, wr_en, rd_en;
  logic [RowIdxW-1:0]   row_sel;
  logic [DataWidth-1:0] wdata_sel, rdata_d, rdata_q;
  logic [StrbW-1:0]     strb_sel;
  logic [DataWidth-1:0] mem_q [BankDepth];

  // First requester at or after the pointer, in cyclic order, wins; nothing is granted in reset.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = PortW'((int'(ptr_q) + i) % NumPorts);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    gnt_valid = found && rst_ni;
    gnt_o     = '0;
    if (gnt_valid) gnt_o[sel] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid) ptr_d = (sel == PortW'(NumPorts - 1)) ? '0 : sel + PortW'(1);
  end

  always_comb begin
    row_sel   = req_row_i[sel];
    wdata_sel = req_wdata_i[sel];
    strb_sel  = req_strb_i[sel];
    wr_en     = gnt_valid && req_write_i[sel];
    rd_en     = gnt_valid && !req_write_i[sel];
    rdata_d   = rd_en ? mem_q[row_sel] : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q   <= '0;
      rdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset so it maps onto plain SRAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int k = 0; k < StrbW; k++) begin
        if (strb_sel[k]) mem_q[row_sel][8*k +: 8] <= wdata_sel[8*k +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/snax_tcdm_responder.sv
// Multi-port banked TCDM scratchpad: decodes requests, fans them out to per-bank
// round-robin arbiters and routes fixed-latency responses back to the ports.
module snax_tcdm_responder
  import snax_tcdm_pkg::*;
#(
  parameter int unsigned DataWidth  = snax_tcdm_pkg::DataWidth,
  parameter int unsigned AddrWidth  = snax_tcdm_pkg::AddrWidth,
  parameter int unsigned NumPorts   = snax_tcdm_pkg::NumPorts,
  parameter int unsigned NumBanks   = snax_tcdm_pkg::NumBanks,
  parameter int unsigned BankDepth  = snax_tcdm_pkg::BankDepth,
  parameter int unsigned RspLatency = snax_tcdm_pkg::RspLatency,
  parameter type tcdm_req_t = snax_tcdm_pkg::tcdm_req_t,
  parameter type tcdm_rsp_t = snax_tcdm_pkg::tcdm_rsp_t
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  snax_tcdm_responder_if.slave tcdm
);

  localparam int unsigned StrbW   = DataWidth / 8;
  localparam int unsigned BankW   = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned RowIdxW = (BankDepth > 1) ? $clog2(BankDepth) : 1;

  tcdm_req_t            req        [NumPorts];
  tcdm_rsp_t            rsp        [NumPorts];
  tcdm_addr_dec_t       port_dec   [NumPorts];
  logic [AddrWidth-1:0] port_addr  [NumPorts];
  logic [BankW-1:0]     port_bank  [NumPorts];
  logic [RowIdxW-1:0]   port_row   [NumPorts];
  logic [DataWidth-1:0] port_wdata [NumPorts];
  logic [StrbW-1:0]     port_strb  [NumPorts];
  logic [NumPorts-1:0]  port_valid, port_write, q_ready;
  logic [NumPorts-1:0]  bank_gnt   [NumBanks];
  logic [DataWidth-1:0] bank_rdata [NumBanks];
  logic                 unused_fields;

  assign req           = tcdm.tcdm_req;
  assign tcdm.tcdm_rsp = rsp;

  // AMO and user fields do not change the access, which is decided by q.write alone.
  always_comb begin
    unused_fields = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      port_valid[p] = req[p].q_valid;
      port_write[p] = req[p].q.write;
      port_addr[p]  = req[p].q.addr;
      port_dec[p]   = decode_addr(port_addr[p]);
      port_bank[p]  = BankW'(port_dec[p].bank);
      port_row[p]   = RowIdxW'(port_dec[p].row);
      port_wdata[p] = req[p].q.data;
      port_strb[p]  = req[p].q.strb;
      unused_fields = unused_fields ^ (^{req[p].q.amo, req[p].q.user});
    end
  end

  for (genvar b = 0; b < NumBanks; b++) begin : gen_bank
    logic [NumPorts-1:0] bank_req;

    always_comb begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[p] = port_valid[p] && (port_bank[p] == BankW'(b));
      end
    end

    snax_tcdm_bank #(
      .NumPorts  (NumPorts),
      .DataWidth (DataWidth),
      .BankDepth (BankDepth),
      .RowIdxW   (RowIdxW),
      .StrbW     (StrbW)
    ) i_bank (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (bank_req),
      .req_row_i   (port_row),
      .req_write_i (port_write),
      .req_wdata_i (port_wdata),
      .req_strb_i  (port_strb),
      .gnt_o       (bank_gnt[b]),
      .rdata_o     (bank_rdata[b])
    );
  end

  // Each port targets a single bank, so OR-ing all bank grants yields its q_ready.
  always_comb begin
    q_ready = '0;
    for (int b = 0; b < NumBanks; b++) q_ready = q_ready | bank_gnt[b];
  end

  logic [NumPorts-1:0]  rsp_vld_d  [RspLatency];
  logic [NumPorts-1:0]  rsp_vld_q  [RspLatency];
  logic [NumPorts-1:0]  rsp_read_d, rsp_read_q;
  logic [BankW-1:0]     rsp_bank_d [NumPorts];
  logic [BankW-1:0]     rsp_bank_q [NumPorts];
  logic [DataWidth-1:0] head_data  [NumPorts];
  logic [DataWidth-1:0] out_data   [NumPorts];
  logic [NumPorts-1:0]  out_vld;

  always_comb begin
    rsp_vld_d[0] = q_ready;
    for (int s = 1; s < RspLatency; s++) rsp_vld_d[s] = rsp_vld_q[s-1];
    rsp_read_d = q_ready & ~port_write;
    for (int p = 0; p < NumPorts; p++) rsp_bank_d[p] = port_bank[p];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < RspLatency; s++) rsp_vld_q[s] <= '0;
      for (int p = 0; p < NumPorts; p++) rsp_bank_q[p] <= '0;
      rsp_read_q <= '0;
    end else begin
      rsp_vld_q  <= rsp_vld_d;
      rsp_bank_q <= rsp_bank_d;
      rsp_read_q <= rsp_read_d;
    end
  end

  // Bank read registers are only stable for the cycle after the grant, so data is picked there.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      head_data[p] = rsp_read_q[p] ? bank_rdata[rsp_bank_q[p]] : '0;
    end
  end

  if (RspLatency == 1) begin : gen_lat1
    always_comb begin
      for (int p = 0; p < NumPorts; p++) out_data[p] = head_data[p];
    end
  end else begin : gen_latn
    logic [DataWidth-1:0] rsp_data_d [RspLatency-1][NumPorts];
    logic [DataWidth-1:0] rsp_data_q [RspLatency-1][NumPorts];

    always_comb begin
      rsp_data_d[0] = head_data;
      for (int s = 1; s < RspLatency - 1; s++) rsp_data_d[s] = rsp_data_q[s-1];
      for (int p = 0; p < NumPorts; p++) out_data[p] = rsp_data_q[RspLatency-2][p];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int s = 0; s < RspLatency - 1; s++) begin
          for (int p = 0; p < NumPorts; p++) rsp_data_q[s][p] <= '0;
        end
      end else begin
        rsp_data_q <= rsp_data_d;
      end
    end
  end

  assign out_vld = rsp_vld_q[RspLatency-1];

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      rsp[p]            = '0;
      rsp[p].q_ready    = q_ready[p];
      rsp[p].p_valid    = out_vld[p];
      rsp[p].p.data     = out_data[p];
    end
  end

endmodule
